// File: rtl/mux_uart_tx.sv
// Memory-mapped UART transmitter: status/data registers, small TX FIFO, 8N1 serializer.
// Latency: write into empty FIFO pops on the next edge; each frame is 10*CLKS_PER_BIT cycles.
// Backpressure: ready=0 when FIFO full; a write while full is dropped and sets sticky overrun.
module mux_uart_tx #(
    parameter logic [15:0] BASE_ADDR    = 16'hF200,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        write_en,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        hit,
    output logic        txd,
    output logic        tx_busy
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [15:0] DATA_ADDR = BASE_ADDR + 16'd1;
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_overrun;
    state_t        r_state;
    logic [15:0]   r_baud;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_txd;

    logic       w_full;
    logic       w_empty;
    logic       w_bit_end;
    logic       w_pop;
    logic       w_push_req;
    logic       w_push;
    logic       w_clr_ovr;
    logic       w_idle;
    logic [7:0] w_head;

    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign w_bit_end  = (r_baud == BIT_LAST);
    assign w_head     = r_mem[r_rptr];
    // The FSM only looks at the registered count, so a push is never bypassed to the pop.
    assign w_pop      = !w_empty && ((r_state == S_IDLE) || (r_state == S_STOP && w_bit_end));
    assign w_push_req = write_en && (address == DATA_ADDR);
    // A pop in the same edge frees a slot, so a full FIFO can still accept.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_clr_ovr  = write_en && (address == BASE_ADDR);
    assign w_idle     = w_empty && (r_state == S_IDLE);

    assign hit      = (address == BASE_ADDR) || (address == DATA_ADDR);
    assign data_out = (address == BASE_ADDR) ?
                      {2'b00, r_overrun, 1'b0, w_idle, 1'b0, !w_full, 1'b0} : 8'h00;
    assign txd      = r_txd;
    assign tx_busy  = !w_empty || (r_state != S_IDLE);

    // FIFO storage: data only, validity is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wptr] <= data_in;
        end
    end

    // FIFO pointers, occupancy and the sticky overrun flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push_req && !w_push) begin
                r_overrun <= 1'b1;
            end else if (w_clr_ovr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Transmit FSM: start bit, 8 data bits LSB first, stop bit; txd is registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_txd     <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_txd <= 1'b1;
                    if (w_pop) begin
                        r_shift   <= w_head;
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_state   <= S_START;
                        r_txd     <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_state <= S_DATA;
                        r_txd   <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                            r_txd   <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_txd     <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift   <= w_head;
                            r_bit_idx <= '0;
                            r_state   <= S_START;
                            r_txd     <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_txd   <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_uart_tx.sv
// Randomized and directed bench for mux_uart_tx against a frame-level reference model.
// Latency: checks every cycle; model tracks frames by position within a 10-bit frame.
// Backpressure: model accepts writes only when fewer than DEPTH bytes are queued or a pop frees a slot.
module tb_mux_uart_tx;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam logic [15:0] STAT  = 16'hF200;
    localparam logic [15:0] DATA  = 16'hF201;
    localparam int          FRAME = 10 * CPB;

    logic        clock;
    logic        reset;
    logic [15:0] address;
    logic        write_en;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        hit;
    logic        txd;
    logic        tx_busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: queued bytes, the byte on the line and its position in the frame.
    logic [7:0] m_q[$];
    logic [7:0] m_cur;
    bit         m_active;
    int         m_pos;
    bit         m_ovr;

    mux_uart_tx #(
        .BASE_ADDR   (STAT),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .address (address),
        .write_en(write_en),
        .data_in (data_in),
        .data_out(data_out),
        .hit     (hit),
        .txd     (txd),
        .tx_busy (tx_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exceeded, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_active = 0;
        m_pos    = 0;
        m_ovr    = 0;
        m_cur    = 8'h00;
    endfunction

    function automatic logic [7:0] model_status();
        logic idle;
        logic ready;
        idle  = (m_q.size() == 0) && !m_active;
        ready = (m_q.size() < DEPTH);
        return {2'b00, m_ovr, 1'b0, idle, 1'b0, ready, 1'b0};
    endfunction

    function automatic logic model_txd();
        int slot;
        if (!m_active) return 1'b1;
        slot = m_pos / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return m_cur[slot-1];
        return 1'b1;
    endfunction

    function automatic void model_edge(input logic [15:0] a, input logic we, input logic [7:0] d);
        bit popping;
        bit req;
        bit accept;
        popping = (m_q.size() != 0) && (!m_active || m_pos == FRAME - 1);
        req     = we && (a == DATA);
        accept  = req && ((m_q.size() < DEPTH) || popping);
        if (popping) begin
            m_cur    = m_q.pop_front();
            m_active = 1;
            m_pos    = 0;
        end else if (m_active) begin
            if (m_pos == FRAME - 1) m_active = 0;
            else m_pos++;
        end
        if (accept) m_q.push_back(d);
        else if (req) m_ovr = 1;
        if (we && a == STAT) m_ovr = 0;
    endfunction

    // One clock: drive inputs, check combinational reads, clock the model, check the line.
    task automatic step(input logic [15:0] a, input logic we, input logic [7:0] d);
        address  = a;
        write_en = we;
        data_in  = d;
        #1;
        chk("hit", hit, (a == STAT) || (a == DATA));
        chk("data_out", data_out, (a == STAT) ? model_status() : 8'h00);
        @(posedge clock);
        model_edge(a, we, d);
        @(negedge clock);
        chk("txd", txd, model_txd());
        chk("tx_busy", tx_busy, m_active || (m_q.size() != 0));
    endtask

    task automatic peek(input string tag, input logic [15:0] a, input logic [7:0] expv);
        address  = a;
        write_en = 1'b0;
        #1;
        chk(tag, data_out, expv);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((m_active || m_q.size() != 0) && n < 20 * FRAME) begin
            step(STAT, 1'b0, 8'h00);
            n++;
        end
        chk({tag, "_drain_timeout"}, (m_active || m_q.size() != 0), 0);
    endtask

    initial begin
        logic [9:0] frame48;
        logic [39:0] line;
        int n;
        int wprob;
        int r;
        logic [15:0] a;

        reset    = 1'b1;
        address  = 16'h0000;
        write_en = 1'b0;
        data_in  = 8'h00;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        chk("rst_txd", txd, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        reset = 1'b0;

        // Status after reset: ready and idle.
        step(STAT, 1'b0, 8'h00);
        chk("r027_stat", data_out, 8'h0A);
        chk("r027_hit", hit, 1'b1);

        // Single frame of 0x48 compared against the literal waveform.
        frame48 = {1'b1, 8'h48, 1'b0};
        step(DATA, 1'b1, 8'h48);
        for (int i = 0; i < FRAME; i++) begin
            step(STAT, 1'b0, 8'h00);
            line[i] = txd;
        end
        for (int i = 0; i < FRAME; i++) begin
            if (line[i] !== frame48[i / CPB]) begin
                chk("r028_wave", {31'd0, line[i]}, {31'd0, frame48[i / CPB]});
            end
        end
        chk("r028_wave_all", line, {{4{frame48[9]}}, {4{frame48[8]}}, {4{frame48[7]}},
            {4{frame48[6]}}, {4{frame48[5]}}, {4{frame48[4]}}, {4{frame48[3]}},
            {4{frame48[2]}}, {4{frame48[1]}}, {4{frame48[0]}}});
        step(STAT, 1'b0, 8'h00);
        chk("r028_stat", data_out, 8'h0A);

        // Six back-to-back writes: fifth fills, sixth overruns.
        for (int i = 0; i < 5; i++) step(DATA, 1'b1, 8'h41 + 8'(i));
        peek("r029_full", STAT, 8'h00);
        step(DATA, 1'b1, 8'h46);
        peek("r029_ovr", STAT, 8'h20);
        step(STAT, 1'b1, 8'hFF);
        peek("r029_clr", STAT, 8'h00);
        chk("r029_busy", tx_busy, 1'b1);

        // Write to a full FIFO exactly on the edge where the stop bit ends.
        n = 0;
        while (!(m_active && m_pos == FRAME - 1) && n < 2 * FRAME) begin
            step(16'h8000, 1'b0, 8'h00);
            n++;
        end
        chk("r030_timeout", (m_active && m_pos == FRAME - 1), 1);
        step(DATA, 1'b1, 8'h99);
        peek("r030_stat", STAT, 8'h00);
        drain("r030");
        step(STAT, 1'b0, 8'h00);

        // Reset pulse in the middle of a data bit.
        step(DATA, 1'b1, 8'hC3);
        n = 0;
        while (!(m_active && m_pos >= 2 * CPB && m_pos < 8 * CPB) && n < 4 * FRAME) begin
            step(STAT, 1'b0, 8'h00);
            n++;
        end
        chk("r031_timeout", (m_active && m_pos >= 2 * CPB), 1);
        #1;
        reset = 1'b1;
        #1;
        chk("r031_txd", txd, 1'b1);
        chk("r031_busy", tx_busy, 1'b0);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        step(STAT, 1'b0, 8'h00);
        chk("r031_stat", data_out, 8'h0A);
        for (int i = 0; i < FRAME; i++) step(16'h8000, 1'b0, 8'h00);

        // Unmapped address: no effect.
        step(16'hF202, 1'b1, 8'h55);
        peek("r032_stat", STAT, 8'h0A);
        address = 16'h8000;
        #1;
        chk("r032_hit", hit, 1'b0);
        chk("r032_dout", data_out, 8'h00);

        // Randomized traffic with varying write density.
        for (int blk = 0; blk < 12; blk++) begin
            wprob = $urandom_range(2, 60);
            for (int i = 0; i < 250; i++) begin
                r = $urandom_range(0, 9);
                if (r <= 4) a = DATA;
                else if (r <= 6) a = STAT;
                else if (r == 7) a = 16'hF202;
                else if (r == 8) a = 16'h8000;
                else a = 16'($urandom);
                step(a, ($urandom_range(0, 99) < wprob), 8'($urandom));
            end
        end
        drain("rand");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux_uart_tx.md
MUX_UART_TX -- requirements
Module: mux_uart_tx

Interface
REQ-001 The block SHALL expose parameter BASE_ADDR, default 16'hF200, the status register address; the data register is BASE_ADDR+1.
REQ-002 The block SHALL expose parameter CLKS_PER_BIT, default 16, the clock cycles per serial bit (legal range 2..65535).
REQ-003 The block SHALL expose parameter FIFO_DEPTH, default 4, the transmit FIFO entries (power of two, 2..16).
REQ-004 clock  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 address  input  16  CPU bus address.
REQ-007 write_en  input  1  CPU bus write strobe, sampled at the rising edge of clock.
REQ-008 data_in  input  8  CPU write data.
REQ-009 data_out  output  8  register read data, combinational from address.
REQ-010 hit  output  1  combinational; 1 when address equals BASE_ADDR or BASE_ADDR+1.
REQ-011 txd  output  1  serial transmit line, idle high.
REQ-012 tx_busy  output  1  1 while the FIFO is non-empty or a frame is in progress.

Function
REQ-013 Status read (address==BASE_ADDR) SHALL return {2'b0, overrun, 1'b0, idle, 1'b0, ready, 1'b0}: ready = FIFO not full; idle = FIFO empty and FSM in IDLE; overrun = sticky flag.
REQ-014 A read of BASE_ADDR+1 SHALL return 8'h00; when hit==0, data_out SHALL be 8'h00.
REQ-015 A write (write_en=1) to BASE_ADDR+1 SHALL push data_in into the FIFO if not full; if full, the byte SHALL be dropped and overrun set.
REQ-016 A write to BASE_ADDR with any data SHALL clear overrun; writes to any other address SHALL be ignored.
REQ-017 Transmit FSM states: IDLE, START, DATA, STOP; frame format 8N1, LSB first.
REQ-018 IDLE: txd=1; on an edge where the FIFO count is nonzero, pop the head into the shift register, clear the baud counter and the bit index, and enter START.
REQ-019 START drives txd=0, DATA drives the current shift bit, STOP drives txd=1; each bit lasts exactly CLKS_PER_BIT cycles, counted by the baud counter.
REQ-020 DATA SHALL advance through 8 bits, then enter STOP; at the end of STOP, pop and enter START if the FIFO is non-empty (back-to-back frames, no idle gap), else enter IDLE.
REQ-021 Latency: a write accepted at edge N into an empty FIFO with the FSM in IDLE SHALL cause the pop and txd=0 at edge N+1; one frame SHALL occupy exactly 10*CLKS_PER_BIT cycles.
REQ-022 Simultaneous push and pop with the FIFO full: the pop frees a slot, the push is accepted, and the count is unchanged.
REQ-023 A push into an empty FIFO is not visible to the FSM until the following edge; no same-cycle bypass.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL range 0..FIFO_DEPTH, with full defined as count==FIFO_DEPTH.

Reset
REQ-025 While reset=1, regardless of clock: FIFO empty, pointers 0, FSM IDLE, counters 0, txd=1, overrun=0, tx_busy=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately (txd=1) and discard all FIFO contents.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-027 Reset released, address=F200 -> data_out=8'h0A, hit=1, txd=1, tx_busy=0.
REQ-028 Write 8'h48 to F201 -> txd=0 for cycles 1-4 after the write, then bits 0,0,0,1,0,0,1,0 for 4 cycles each, stop=1; F200 reads 8'h0A after 40 cycles.
REQ-029 Six back-to-back writes to F201 (8'h41..8'h46) -> after the fifth, F200=8'h00; the sixth is dropped and F200=8'h20; the line carries exactly 5 frames (41..45); a write to F200 then returns F200 to 8'h00 while busy.
REQ-030 FIFO full, write on the STOP-to-START edge -> accepted, count unchanged, no overrun.
REQ-031 Reset pulsed during DATA of a frame -> txd=1 within the same cycle; after release F200=8'h0A and no further frames are sent.
REQ-032 Write to F202 and read of 8000 -> hit=0, data_out=8'h00, FIFO and overrun unchanged.
